// File: rtl/ysyx_220066_mem_arb.sv
// ysyx_220066 memory arbiter: shares one downstream memory port between
// instruction fetch and data load/store, one transaction at a time.
module ysyx_220066_mem_arb #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [31:0]       if_instr,
  output logic              if_error,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_wmask,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Select the 32-bit instruction word addressed by bit 2 of the fetch address.
  function automatic logic [31:0] pick_word(input logic hi, input logic [DATA_W-1:0] d);
    logic [31:0] w;
    if (hi) begin
      w = d[63:32];
    end else begin
      w = d[31:0];
    end
    return w;
  endfunction

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = data port owns the transaction
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic              mem_req_q, mem_req_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_error_q, if_error_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_error_q, d_error_d;

  logic              grant_d_s, grant_i_s;
  logic              resp_fire_s, resp_err_s;
  logic [DATA_W-1:0] resp_data_s;
  logic [TW-1:0]     tmo_inc_s;
  logic              tmo_hit_s;

  // Arbitration: data wins unless the fetch port has already been passed over STARVE_MAX times.
  always_comb begin
    grant_d_s = (state_q == S_IDLE) && d_req &&
                ((starve_q < SW'(STARVE_MAX)) || !if_req);
    grant_i_s = (state_q == S_IDLE) && if_req && !grant_d_s;
  end

  assign if_ready  = grant_i_s;
  assign d_ready   = grant_d_s;
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rvalid = if_rvalid_q;
  assign if_instr  = if_instr_q;
  assign if_error  = if_error_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_error   = d_error_q;

  // Next-state, latched request fields, timeout and response computation.
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    misalign_d  = misalign_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mem_req_d   = mem_req_q;
    tmo_d       = tmo_q;
    if_rvalid_d = 1'b0;
    if_instr_d  = if_instr_q;
    if_error_d  = if_error_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_error_d   = d_error_q;
    resp_fire_s = 1'b0;
    resp_err_s  = 1'b0;
    resp_data_s = {DATA_W{1'b0}};
    // Saturate so a late grant landing in WAIT cannot wrap the counter.
    if (tmo_q == {TW{1'b1}}) begin
      tmo_inc_s = tmo_q;
    end else begin
      tmo_inc_s = tmo_q + TW'(1);
    end
    tmo_hit_s = (tmo_q >= TW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        if (grant_d_s) begin
          owner_d_d  = 1'b1;
          misalign_d = 1'b0;
          addr_d     = d_addr;
          we_d       = d_we;
          wdata_d    = d_wdata;
          wmask_d    = d_wmask;
          mem_req_d  = 1'b1;
          tmo_d      = {TW{1'b0}};
          state_d    = S_ISSUE;
        end else if (grant_i_s) begin
          owner_d_d  = 1'b0;
          misalign_d = (if_addr[1:0] != 2'b00);
          addr_d     = if_addr;
          we_d       = 1'b0;
          wdata_d    = {DATA_W{1'b0}};
          wmask_d    = 8'h00;
          // A misaligned fetch never reaches memory; it is failed in the response slot.
          mem_req_d  = (if_addr[1:0] == 2'b00);
          tmo_d      = {TW{1'b0}};
          state_d    = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        tmo_d = tmo_inc_s;
        if (misalign_q) begin
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else if (mem_gnt && mem_rvalid) begin
          resp_fire_s = 1'b1;
          resp_err_s  = mem_err;
          resp_data_s = mem_rdata;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end else if (tmo_hit_s) begin
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_inc_s;
        if (mem_rvalid) begin
          resp_fire_s = 1'b1;
          resp_err_s  = mem_err;
          resp_data_s = mem_rdata;
        end else if (tmo_hit_s) begin
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (resp_fire_s) begin
      state_d   = S_RESP;
      mem_req_d = 1'b0;
      if (owner_d_q) begin
        d_rvalid_d = 1'b1;
        d_error_d  = resp_err_s;
        if (we_q) begin
          d_rdata_d = {DATA_W{1'b0}};
        end else begin
          d_rdata_d = resp_data_s;
        end
      end else begin
        if_rvalid_d = 1'b1;
        if_error_d  = resp_err_s;
        if_instr_d  = pick_word(addr_q[2], resp_data_s);
      end
    end else begin
      resp_err_s = 1'b0;
    end
  end

  // Starvation counter: counts data grants taken while a fetch is waiting.
  always_comb begin
    if (!if_req) begin
      starve_d = {SW{1'b0}};
    end else if (grant_d_s) begin
      if (starve_q == SW'(STARVE_MAX)) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end else if (grant_i_s) begin
      starve_d = {SW{1'b0}};
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers with synchronous reset that abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      misalign_q  <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= {DATA_W{1'b0}};
      wmask_q     <= 8'h00;
      mem_req_q   <= 1'b0;
      tmo_q       <= {TW{1'b0}};
      starve_q    <= {SW{1'b0}};
      if_rvalid_q <= 1'b0;
      if_instr_q  <= 32'h0000_0000;
      if_error_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= {DATA_W{1'b0}};
      d_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      misalign_q  <= misalign_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_req_q   <= mem_req_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_instr_q  <= if_instr_d;
      if_error_q  <= if_error_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_error_q   <= d_error_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Directed bench for ysyx_220066_mem_arb: fetch/store/load flows, arbitration
// fairness, timeout, misaligned fetch and reset abandonment.
module tb_ysyx_220066_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready, if_rvalid, if_error;
  logic [31:0] if_instr;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        d_ready, d_rvalid, d_error;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [63:0] mem_rdata;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0]  seq;
  int          ng;
  int          cnt;
  int          rv_idx;
  logic        rv_err;
  logic [31:0] rv_instr;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  ysyx_220066_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_instr(if_instr), .if_error(if_error),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(d_ready), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_error(d_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 64'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_wmask = 8'h00;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_err = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk64("rst_mem_addr", mem_addr, 64'd0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk64("rst_d_rdata", d_rdata, 64'd0);
    chk64("rst_if_instr", 64'(if_instr), 64'd0);
    tick();

    // 1. Zero-wait fetch at 0x80000004
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0004;
    #1;
    chk1("t1_if_ready", if_ready, 1'b1);
    chk1("t1_d_ready", d_ready, 1'b0);
    chk1("t1_busy_c0", busy, 1'b0);
    tick();
    if_req = 1'b0; if_addr = 64'hFFFF;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0013_0010_0093;
    #1;
    chk1("t1_mem_req", mem_req, 1'b1);
    chk64("t1_mem_addr", mem_addr, 64'h0000_0000_8000_0004);
    chk1("t1_mem_we", mem_we, 1'b0);
    chk1("t1_busy_c1", busy, 1'b1);
    chk1("t1_rvalid_c1", if_rvalid, 1'b0);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk1("t1_if_rvalid", if_rvalid, 1'b1);
    chk64("t1_if_instr", 64'(if_instr), 64'h0000_0013);
    chk1("t1_if_error", if_error, 1'b0);
    chk1("t1_busy_c2", busy, 1'b1);
    chk1("t1_d_rvalid", d_rvalid, 1'b0);
    chk1("t1_mem_req_c2", mem_req, 1'b0);
    tick();
    #1;
    chk1("t1_rvalid_c3", if_rvalid, 1'b0);
    chk1("t1_busy_c3", busy, 1'b0);
    chk64("t1_instr_hold", 64'(if_instr), 64'h0000_0013);

    // 2. Store, grant after 3 cycles, completion 2 cycles later
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h0000_0000_8000_1000;
    d_wdata = 64'h1122_3344_5566_7788; d_wmask = 8'h0F;
    #1;
    chk1("t2_d_ready", d_ready, 1'b1);
    chk1("t2_if_ready", if_ready, 1'b0);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_addr = 64'h1234; d_wdata = 64'd0; d_wmask = 8'hFF;
    for (int k = 1; k <= 3; k++) begin
      mem_gnt = (k == 3);
      #1;
      chk1("t2_mem_req", mem_req, 1'b1);
      chk1("t2_mem_we", mem_we, 1'b1);
      chk64("t2_mem_addr", mem_addr, 64'h0000_0000_8000_1000);
      chk64("t2_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      chk64("t2_mem_wmask", 64'(mem_wmask), 64'h0F);
      tick();
    end
    mem_gnt = 1'b0;
    #1;
    chk1("t2_wait_req", mem_req, 1'b0);
    chk1("t2_wait_busy", busy, 1'b1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk1("t2_no_early_rvalid", d_rvalid, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk1("t2_d_rvalid", d_rvalid, 1'b1);
    chk64("t2_d_rdata", d_rdata, 64'd0);
    chk1("t2_d_error", d_error, 1'b0);
    chk1("t2_if_rvalid", if_rvalid, 1'b0);
    tick();
    #1;
    chk1("t2_d_rvalid_end", d_rvalid, 1'b0);
    chk1("t2_busy_end", busy, 1'b0);

    // 3. Both requesters continuously, zero-wait memory
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0000_0000_8000_2000;
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0100;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    ng = 0; seq = 10'd0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      #1;
      chk1("t3_excl", d_ready & if_ready, 1'b0);
      if (d_ready) begin
        seq = {seq[8:0], 1'b1}; ng++;
      end else if (if_ready) begin
        seq = {seq[8:0], 1'b0}; ng++;
      end
      tick();
    end
    chk64("t3_grants", 64'(ng), 64'd10);
    chk64("t3_order", 64'(seq), 64'(10'b11110_11110));
    d_req = 1'b0; if_req = 1'b0;
    tick();
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk1("t3_idle", busy, 1'b0);

    // 4. Timeout: no grant ever
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0008;
    #1;
    chk1("t4_if_ready", if_ready, 1'b1);
    tick();
    if_req = 1'b0;
    cnt = 0; rv_idx = 0; rv_err = 1'b0; rv_instr = 32'hFFFF_FFFF;
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (if_rvalid) begin
        rv_idx = k; rv_err = if_error; rv_instr = if_instr;
        break;
      end
      if (mem_req) cnt++;
      tick();
    end
    chk64("t4_rvalid_cycle", 64'(rv_idx), 64'd256);
    chk64("t4_req_cycles", 64'(cnt), 64'd255);
    chk1("t4_error", rv_err, 1'b1);
    chk64("t4_instr", 64'(rv_instr), 64'd0);
    tick();
    #1;
    chk1("t4_busy_fall", busy, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("t4_stray_if", if_rvalid, 1'b0);
      chk1("t4_stray_d", d_rvalid, 1'b0);
      tick();
    end

    // 5a. Load with memory error
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h0000_0000_8000_3000;
    #1;
    chk1("t5_d_ready", d_ready, 1'b1);
    tick();
    d_req = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 64'h0000_0000_0000_DEAD;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk1("t5_d_rvalid", d_rvalid, 1'b1);
    chk1("t5_d_error", d_error, 1'b1);
    chk64("t5_d_rdata", d_rdata, 64'h0000_0000_0000_DEAD);
    tick();

    // 5b. Misaligned fetch
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0002;
    #1;
    chk1("t5b_if_ready", if_ready, 1'b1);
    tick();
    if_req = 1'b0;
    #1;
    chk1("t5b_no_req_c1", mem_req, 1'b0);
    chk1("t5b_busy_c1", busy, 1'b1);
    chk1("t5b_no_rvalid_c1", if_rvalid, 1'b0);
    tick();
    #1;
    chk1("t5b_if_rvalid", if_rvalid, 1'b1);
    chk1("t5b_if_error", if_error, 1'b1);
    chk1("t5b_no_req_c2", mem_req, 1'b0);
    chk64("t5b_d_rdata_hold", d_rdata, 64'h0000_0000_0000_DEAD);
    tick();
    #1;
    chk1("t5b_busy_end", busy, 1'b0);

    // 6. Reset while waiting for completion
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0010;
    #1;
    chk1("t6_if_ready", if_ready, 1'b1);
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    #1;
    chk1("t6_mem_req", mem_req, 1'b1);
    tick();
    mem_gnt = 1'b0;
    #1;
    chk1("t6_wait_req", mem_req, 1'b0);
    chk1("t6_wait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
    #1;
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_mem_req", mem_req, 1'b0);
    chk64("t6_rst_mem_addr", mem_addr, 64'd0);
    chk1("t6_rst_rvalid", if_rvalid, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1("t6_no_pulse", if_rvalid, 1'b0);
      tick();
    end
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0000;
    #1;
    chk1("t6_refetch_ready", if_ready, 1'b1);
    tick();
    if_req = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hABCD_0123_0050_0113;
    #1;
    chk64("t6_refetch_addr", mem_addr, 64'h0000_0000_8000_0000);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk1("t6_refetch_rvalid", if_rvalid, 1'b1);
    chk64("t6_refetch_instr", 64'(if_instr), 64'h0050_0113);
    chk1("t6_refetch_error", if_error, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
